// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, init ROM and helpers for the HD44780-style LCD controller.
package lcd_pkg;
    typedef enum logic [2:0] {PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT} lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    localparam int INIT_LEN = 4;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    localparam logic [7:0] LCD_CMD_CLR  = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME = 8'h02;

    // clear and home (0x02/0x03) need the long post-access wait
    function automatic logic is_slow(lcd_entry_t e);
        return !e.rs && (e.data == LCD_CMD_CLR || e.data[7:1] == LCD_CMD_HOME[7:1]);
    endfunction

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = level_q == LW'(DEPTH);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign data_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= do_push ? wptr_q + AW'(1) : wptr_q;
            rptr_q  <= do_pop ? rptr_q + AW'(1) : rptr_q;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: character-LCD write controller; FIFO-fed {rs, byte} accesses with
// hardware SETUP/PULSE/HOLD/WAIT timing and an optional power-on init sequence.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int T_PWRUP_CYC = 405000,
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 13,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 1080,
    parameter int T_CLR_CYC   = 44280,
    parameter int INIT_EN     = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic                          wr_rs_i,
    input  logic [7:0]                    wr_data_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          done_o,
    output logic                          init_done_o,
    output logic                          lcd_on_o,
    output logic                          lcd_en_o,
    output logic                          lcd_rs_o,
    output logic                          lcd_rw_o,
    output logic [7:0]                    lcd_data_o
);
    localparam int T_MAX = max2(max2(max2(T_PWRUP_CYC, T_SETUP_CYC), max2(T_EN_CYC, T_HOLD_CYC)),
                                max2(T_CMD_CYC, T_CLR_CYC));
    localparam int CW = $clog2(T_MAX) + 1;
    localparam int IW = $clog2(INIT_LEN);

    lcd_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    lcd_entry_t     ent_q, ent_d, head, wr_ent;
    logic           en_q, en_d, on_q, init_done_q, init_done_d;
    logic           pop, full, empty, cnt_zero;

    assign wr_ent = '{rs: wr_rs_i, data: wr_data_i};

    sync_fifo #(.WIDTH($bits(lcd_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wr_valid_i),
        .pop_i   (pop),
        .data_i  (wr_ent),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level_o)
    );

    assign cnt_zero    = cnt_q == '0;
    assign wr_ready_o  = !full;
    assign busy_o      = !(state_q == IDLE && empty);
    assign done_o      = state_q == WAIT && cnt_zero;
    assign init_done_o = init_done_q;
    assign lcd_on_o    = on_q;
    assign lcd_en_o    = en_q;
    assign lcd_rs_o    = ent_q.rs;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = ent_q.data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_zero ? cnt_q : cnt_q - CW'(1);
        idx_d       = idx_q;
        ent_d       = ent_q;
        en_d        = en_q;
        init_done_d = init_done_q;
        pop         = 1'b0;
        case (state_q)
            PWRUP: begin
                // the first cycle out of reset loads the counter, so the exit lands T_PWRUP_CYC edges after release
                if (!on_q) begin
                    cnt_d = CW'(T_PWRUP_CYC - 2);
                end else if (cnt_zero) begin
                    state_d     = (INIT_EN != 0) ? INIT_LOAD : IDLE;
                    init_done_d = (INIT_EN == 0);
                end
            end
            INIT_LOAD: begin
                ent_d   = '{rs: 1'b0, data: INIT_ROM[idx_q]};
                state_d = SETUP;
                cnt_d   = CW'(T_SETUP_CYC - 1);
            end
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    ent_d   = head;
                    state_d = SETUP;
                    cnt_d   = CW'(T_SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = PULSE;
                    en_d    = 1'b1;
                    cnt_d   = CW'(T_EN_CYC - 1);
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                    en_d    = 1'b0;
                    cnt_d   = CW'(T_HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d = WAIT;
                    cnt_d   = is_slow(ent_q) ? CW'(T_CLR_CYC - 1) : CW'(T_CMD_CYC - 1);
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    if (init_done_q || idx_q == IW'(INIT_LEN - 1)) begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = INIT_LOAD;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= PWRUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            ent_q       <= '0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ent_q       <= ent_d;
            en_q        <= en_d;
            on_q        <= 1'b1;
            init_done_q <= init_done_d;
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed table-driven bench for lcd_ctrl (init, latency, FIFO full, waits, reset, no-init).
module tb_lcd_ctrl;
    localparam int T_PWRUP = 20, T_SETUP = 2, T_EN = 4, T_HOLD = 2, T_CMD = 10, T_CLR = 50, DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, valid, rs_in, ready, busy, done, init_done, on, en, rs, rw;
    logic [7:0] din, data;
    logic [2:0] level;
    logic       rst1_n, valid1, ready1, busy1, done1, init_done1, on1, en1, rs1, rw1;
    logic [7:0] data1;
    logic [2:0] level1;

    lcd_ctrl #(.FIFO_DEPTH(DEPTH), .T_PWRUP_CYC(T_PWRUP), .T_SETUP_CYC(T_SETUP), .T_EN_CYC(T_EN),
               .T_HOLD_CYC(T_HOLD), .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR), .INIT_EN(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(valid), .wr_ready_o(ready), .wr_rs_i(rs_in),
        .wr_data_i(din), .busy_o(busy), .fifo_level_o(level), .done_o(done), .init_done_o(init_done),
        .lcd_on_o(on), .lcd_en_o(en), .lcd_rs_o(rs), .lcd_rw_o(rw), .lcd_data_o(data));

    lcd_ctrl #(.FIFO_DEPTH(DEPTH), .T_PWRUP_CYC(T_PWRUP), .T_SETUP_CYC(T_SETUP), .T_EN_CYC(T_EN),
               .T_HOLD_CYC(T_HOLD), .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR), .INIT_EN(0)) dut1 (
        .clk_i(clk), .rst_ni(rst1_n), .wr_valid_i(valid1), .wr_ready_o(ready1), .wr_rs_i(1'b1),
        .wr_data_i(8'h7A), .busy_o(busy1), .fifo_level_o(level1), .done_o(done1), .init_done_o(init_done1),
        .lcd_on_o(on1), .lcd_en_o(en1), .lcd_rs_o(rs1), .lcd_rw_o(rw1), .lcd_data_o(data1));

    typedef struct {logic rs; logic [7:0] data; int en_w; int wt; logic idone;} acc_t;
    typedef struct {logic rs; logic [7:0] data; int wt; logic idone;} exp_t;
    typedef struct {logic rs; logic [7:0] data; int lvl; logic rdy;} push_t;

    acc_t  acc_q[$];
    exp_t  exp_tab[13];
    push_t push_tab[6];
    int    total = 0, bad = 0, cyc = 0, stab_err = 0, rw_err = 0, rise_c = 0, fall_c = 0;
    logic [8:0] cur, cap, h1, h2;
    logic  en_prev = 1'b0, active = 1'b0;

    always @(posedge clk) cyc++;

    // access monitor: EN width, post-access wait and data stability, logged at each done pulse
    always @(negedge clk) begin
        cur = {rs, data};
        if (!rst_n) begin
            en_prev = 1'b0;
            active  = 1'b0;
        end else begin
            if (rw) rw_err++;
            if (en && !en_prev) begin
                rise_c = cyc;
                cap    = cur;
                active = 1'b1;
                if (h1 != cur || h2 != cur) stab_err++;
            end else if (active && cur != cap) stab_err++;
            if (!en && en_prev) fall_c = cyc;
            if (done) begin
                acc_q.push_back('{cap[8], cap[7:0], fall_c - rise_c, cyc - fall_c - T_HOLD + 1, init_done});
                active = 1'b0;
            end
            en_prev = en;
        end
        h2 = h1;
        h1 = cur;
    end

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("acc_count", acc_q.size(), n);
    endtask

    task automatic push(input logic r, input logic [7:0] d);
        valid = 1'b1;
        rs_in = r;
        din   = d;
        step();
        valid = 1'b0;
    endtask

    task automatic check_acc(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            chk($sformatf("acc%0d_rs", i), acc_q[i].rs, exp_tab[i].rs);
            chk($sformatf("acc%0d_data", i), acc_q[i].data, exp_tab[i].data);
            chk($sformatf("acc%0d_en_w", i), acc_q[i].en_w, T_EN);
            chk($sformatf("acc%0d_wait", i), acc_q[i].wt, exp_tab[i].wt);
            chk($sformatf("acc%0d_idone", i), acc_q[i].idone, exp_tab[i].idone);
        end
    endtask

    initial begin
        int k;
        logic en_seen;
        exp_tab[0]  = '{1'b0, 8'h38, T_CMD, 1'b0};
        exp_tab[1]  = '{1'b0, 8'h0C, T_CMD, 1'b0};
        exp_tab[2]  = '{1'b0, 8'h01, T_CLR, 1'b0};
        exp_tab[3]  = '{1'b0, 8'h06, T_CMD, 1'b0};
        exp_tab[4]  = '{1'b1, 8'h41, T_CMD, 1'b1};
        exp_tab[5]  = '{1'b1, 8'h30, T_CMD, 1'b1};
        exp_tab[6]  = '{1'b1, 8'h31, T_CMD, 1'b1};
        exp_tab[7]  = '{1'b0, 8'hC0, T_CMD, 1'b1};
        exp_tab[8]  = '{1'b1, 8'h33, T_CMD, 1'b1};
        exp_tab[9]  = '{1'b1, 8'h34, T_CMD, 1'b1};
        exp_tab[10] = '{1'b0, 8'h02, T_CLR, 1'b1};
        exp_tab[11] = '{1'b0, 8'h80, T_CMD, 1'b1};
        exp_tab[12] = '{1'b1, 8'h01, T_CMD, 1'b1};
        push_tab[0] = '{1'b1, 8'h31, 1, 1'b1};
        push_tab[1] = '{1'b0, 8'hC0, 2, 1'b1};
        push_tab[2] = '{1'b1, 8'h33, 3, 1'b1};
        push_tab[3] = '{1'b1, 8'h34, 4, 1'b0};
        push_tab[4] = '{1'b1, 8'h35, 4, 1'b0};
        push_tab[5] = '{1'b1, 8'h36, 4, 1'b0};

        rst_n = 1'b0; rst1_n = 1'b0; valid = 1'b0; valid1 = 1'b0; rs_in = 1'b0; din = 8'h00;
        step(); step();
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 1);
        chk("rst_level", level, 0);
        chk("rst_done", done, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_lcd_pins", {on, en, rs, rw, data}, 0);

        rst_n = 1'b1;
        step();
        chk("on_after_release", on, 1);
        wait_acc(4, 1000);
        check_acc(0, 3);
        chk("init_done_after_init", init_done, 1);
        chk("busy_idle", busy, 0);

        // single push latency: data two cycles after push, EN two cycles after that
        valid = 1'b1; rs_in = 1'b1; din = 8'h41;
        step();
        valid = 1'b0;
        chk("lat_c1_level", level, 1);
        chk("lat_c1_data_old", data, 8'h06);
        step();
        chk("lat_c2_data", data, 8'h41);
        chk("lat_c2_rs", rs, 1);
        chk("lat_c2_en", en, 0);
        chk("lat_c2_level", level, 0);
        step();
        chk("lat_c3_en", en, 0);
        step();
        chk("lat_c4_en", en, 1);
        wait_acc(5, 500);
        check_acc(4, 4);

        // fill the FIFO while an access is in flight; pushes past full are dropped
        push(1'b1, 8'h30);
        foreach (push_tab[i]) begin
            valid = 1'b1;
            rs_in = push_tab[i].rs;
            din   = push_tab[i].data;
            step();
            chk($sformatf("push%0d_level", i), level, push_tab[i].lvl);
            chk($sformatf("push%0d_ready", i), ready, push_tab[i].rdy);
        end
        valid = 1'b0;
        wait_acc(10, 1000);

        push(1'b0, 8'h02);
        push(1'b0, 8'h80);
        push(1'b1, 8'h01);
        wait_acc(13, 1000);
        repeat (40) step();
        chk("acc_total_before_reset", acc_q.size(), 13);
        check_acc(5, 12);
        chk("stab_err", stab_err, 0);

        // asynchronous reset in the middle of an EN pulse
        push(1'b1, 8'h55);
        push(1'b1, 8'h66);
        k = 0;
        while (!en && k < 200) begin
            step();
            k++;
        end
        chk("reached_pulse", en, 1);
        chk("pulse_data", data, 8'h55);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_en", en, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_init_done", init_done, 0);
        step();
        acc_q.delete();
        rst_n = 1'b1;
        wait_acc(4, 1000);
        repeat (100) step();
        chk("acc_after_reset", acc_q.size(), 4);
        check_acc(0, 3);
        chk("stab_err_after_reset", stab_err, 0);
        chk("rw_err", rw_err, 0);

        // INIT_EN = 0: no init pulses, push during PWRUP runs straight after
        rst1_n = 1'b1;
        k = 0;
        en_seen = 1'b0;
        while (!init_done1 && k < 100) begin
            step();
            k++;
            valid1 = (k == 3);
            en_seen |= en1;
        end
        chk("noinit_done_edge", k, T_PWRUP);
        chk("noinit_no_en", en_seen, 0);
        chk("noinit_level", level1, 1);
        step();
        chk("noinit_data", data1, 8'h7A);
        chk("noinit_rs", rs1, 1);
        chk("noinit_en_setup", en1, 0);
        step();
        chk("noinit_en_setup2", en1, 0);
        step();
        chk("noinit_en_pulse", en1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Parametrised HD44780-style character-LCD controller with a write FIFO.
- Replaces software bit-banging of the 28-bit LCD I/O word: the CPU's LCD store port pushes {rs, byte} entries, and the block generates RS/RW/EN/DATA timing in hardware.
- Optionally runs the power-on init sequence itself.
- Sits between the pipeline's memory-mapped LCD register and the board LCD pins in the top-level board wrapper.

Parameters:
- FIFO_DEPTH, 8: write-FIFO entries; power of 2, at least 2.
- T_PWRUP_CYC, 405000: cycles to wait after reset before the first LCD access (15 ms at 27 MHz).
- T_SETUP_CYC, 2: cycles RS/DATA are stable before EN rises; at least 1.
- T_EN_CYC, 13: EN high width in cycles; at least 1.
- T_HOLD_CYC, 2: cycles RS/DATA are held after EN falls; at least 1.
- T_CMD_CYC, 1080: post-access wait for normal commands and data (40 us).
- T_CLR_CYC, 44280: post-access wait for clear (0x01) and home (0x02/0x03) commands (1.64 ms).
- INIT_EN, 1: 1 = send the init ROM after power-up; 0 = go straight to idle after T_PWRUP_CYC.

Ports:
- clk_i, input, 1: system clock.
- rst_ni, input, 1: asynchronous active-low reset.
- wr_valid_i, input, 1: write request.
- wr_ready_o, output, 1: FIFO not full.
- wr_rs_i, input, 1: 0 = command, 1 = data.
- wr_data_i, input, 8: byte to send.
- busy_o, output, 1: FSM not idle, or FIFO not empty.
- fifo_level_o, output, $clog2(FIFO_DEPTH)+1: number of FIFO entries.
- done_o, output, 1: one-cycle pulse at the end of each access's post-wait.
- init_done_o, output, 1: power-up and init complete; sticky until reset.
- lcd_on_o, output, 1: LCD power.
- lcd_en_o, output, 1: LCD enable strobe.
- lcd_rs_o, output, 1: LCD register select.
- lcd_rw_o, output, 1: LCD read/write select.
- lcd_data_o, output, 8: LCD data bus.

Behaviour:
- Clocking and reset: one clock. rst_ni is asynchronous, active-low; asserting it at any time forces all state to reset immediately.
- Reset values:
  - wr_ready_o = 1, busy_o = 1, fifo_level_o = 0, done_o = 0, init_done_o = 0.
  - lcd_on_o = 0, lcd_en_o = 0, lcd_rs_o = 0, lcd_rw_o = 0, lcd_data_o = 0x00.
  - FIFO flushed, FSM in PWRUP, counter = 0.
- Reset mid-access: EN drops immediately; the partial access is abandoned and not replayed.
- Outputs: all LCD outputs are registered. lcd_rw_o is constant 0 (write-only). lcd_on_o goes to 1 on the first clock edge after reset release.
- FIFO push/pop:
  - Push when wr_valid_i and wr_ready_o. wr_ready_o = !full.
  - A push while full is ignored: no overwrite and no level change.
  - Simultaneous push and pop in one cycle leaves the level unchanged.
  - The FIFO accepts pushes during PWRUP and INIT; they are executed after init.
- FSM states: PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT.
  - PWRUP: count T_PWRUP_CYC cycles, then go to INIT_LOAD if INIT_EN, otherwise to IDLE (set init_done_o).
  - INIT_LOAD: fetch init ROM entry idx (command, rs = 0), go to SETUP. After the last entry's WAIT, set init_done_o and go to IDLE.
  - IDLE: if FIFO not empty, pop the head, latch rs/data onto the outputs, go to SETUP.
  - SETUP: EN = 0, held for T_SETUP_CYC cycles, then PULSE.
  - PULSE: EN = 1, held for T_EN_CYC cycles, then HOLD.
  - HOLD: EN = 0 with data and rs unchanged, held for T_HOLD_CYC cycles, then WAIT.
  - WAIT: hold for T_CMD_CYC cycles, or T_CLR_CYC if rs = 0 and data[7:2] = 0 and data != 0x00. Pulse done_o in the last WAIT cycle. Then go to IDLE, or to the next init entry during init.
- Init ROM: 0x38, 0x0C, 0x01, 0x06. The 0x01 entry takes T_CLR_CYC.
- Data and rs change only on entry to SETUP; they are stable throughout SETUP, PULSE, HOLD and WAIT.
- Latency from an accepted push, with the FSM idle and the FIFO empty:
  - Push edge at cycle 0.
  - Pop at cycle 1.
  - lcd_data_o valid in cycle 2.
  - EN rises in cycle 2 + T_SETUP_CYC.
- Access period: SETUP + PULSE + HOLD + WAIT cycles plus 1 IDLE cycle. Back-to-back entries leave exactly one IDLE cycle between a WAIT and the next SETUP.
- Counter: one down-counter, width $clog2(max of all T_*)+1. It is loaded with T−1 on state entry, and the state exits when the count is 0.
- busy_o is 0 only in IDLE with the FIFO empty.

Decomposition:
- Package lcd_pkg holds:
  - state enum lcd_state_e;
  - init ROM as a localparam array plus its length;
  - command constants LCD_CMD_CLR = 0x01, LCD_CMD_HOME = 0x02;
  - the entry struct {rs, data[7:0]}.
- Sub-module sync_fifo: parametrised WIDTH/DEPTH, with push/pop/full/empty/level. The FSM and timing stay in lcd_ctrl.

Test Plan:
All scenarios use T_PWRUP = 20, T_SETUP = 2, T_EN = 4, T_HOLD = 2, T_CMD = 10, T_CLR = 50, FIFO_DEPTH = 4.
- Power-up with INIT_EN = 1, no pushes -> exactly 4 EN pulses carrying 0x38, 0x0C, 0x01, 0x06 with rs = 0. The gap after 0x01 is 50 wait cycles, the others 10. init_done_o rises after the 4th done_o. lcd_rw_o stays 0.
- After init, push (rs = 1, 0x41) -> lcd_data_o = 0x41 and rs = 1 two cycles after the push. EN high for exactly 4 cycles, starting 2 cycles later. Data stable from 2 cycles before EN rises to 2 cycles after it falls. done_o pulses once, 10 cycles after HOLD ends.
- Six pushes back-to-back while busy -> first 4 accepted. wr_ready_o = 0 at level 4. Pushes 5 and 6 are dropped. Exactly 4 accesses occur, in order.
- Push (rs = 0, 0x02) then (rs = 0, 0x80) -> 50 wait cycles after the first access, 10 after the second. Push (rs = 1, 0x01) -> 10 wait cycles (data, not clear).
- Assert rst_ni during PULSE -> lcd_en_o = 0 and fifo_level_o = 0 in the same cycle. After release, the full power-up sequence restarts and the aborted byte is never re-sent.
- INIT_EN = 0 -> init_done_o rises 20 cycles after reset with no EN pulse. A push sent during PWRUP executes right after.
